uart_rx_cmd_decoder: RTL and testbench



---
 rtl/uart_rx_cmd_decoder.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_cmd_decoder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_decoder.sv
// Decodes UART command frames (reg write / reg read / ALU with or without operands)
// into registered register-file and ALU strobes. Inter-byte timeout: define CMD_TIMEOUT_EN.
module uart_rx_cmd_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  CLK_GATE_EN,
    output logic                  cmd_err,
    output logic                  busy,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ADDR  = 3'd1,
        WR_DATA  = 3'd2,
        RD_ADDR  = 3'd3,
        OP_A     = 3'd4,
        OP_B     = 3'd5,
        ALU_FUNC = 3'd6
    } state_t;

    localparam logic [DATA_WIDTH-1:0] OPC_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OPC_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OPC_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OPC_ALU_NOP = DATA_WIDTH'(8'hDD);

    state_t                  state;
    state_t                  state_next;
    logic                    wr_en_next;
    logic                    rd_en_next;
    logic                    alu_en_next;
    logic                    err_next;
    logic                    gate_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [DATA_WIDTH-1:0]   wdata_next;
    logic [3:0]              fun_next;

    // Byte stream seen by the FSM. RX_D_VLD is valid-only (no ready): the receiver
    // cannot be stalled, so every pulse must be consumed in the cycle it is seen.
    logic                    byte_vld;
    logic [DATA_WIDTH-1:0]   byte_data;
    logic                    tmo_fire;

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]        tmo_cnt;
    logic                    pend_vld;
    logic [DATA_WIDTH-1:0]   pend_data;

    assign tmo_fire  = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign byte_vld  = tmo_fire ? 1'b0 : (pend_vld | RX_D_VLD);
    assign byte_data = pend_vld ? pend_data : RX_P_DATA;

    // A byte colliding with the abort is parked for one cycle and then decoded from
    // IDLE; while parked, further back-to-back bytes ripple through this one slot.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmo_cnt   <= '0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
        end else begin
            if (byte_vld || (state == IDLE)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (tmo_fire || pend_vld) begin
                pend_vld  <= RX_D_VLD;
                pend_data <= RX_P_DATA;
            end
        end
    end
`else
    assign tmo_fire  = 1'b0;
    assign byte_vld  = RX_D_VLD;
    assign byte_data = RX_P_DATA;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= 4'h0;
            CLK_GATE_EN <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= state_next;
            RF_WrEn     <= wr_en_next;
            RF_RdEn     <= rd_en_next;
            RF_Address  <= addr_next;
            RF_WrData   <= wdata_next;
            ALU_EN      <= alu_en_next;
            ALU_FUN     <= fun_next;
            CLK_GATE_EN <= gate_next;
            cmd_err     <= err_next;
        end
    end

    always_comb begin
        state_next  = state;
        wr_en_next  = 1'b0;
        rd_en_next  = 1'b0;
        alu_en_next = 1'b0;
        err_next    = 1'b0;
        addr_next   = RF_Address;
        wdata_next  = RF_WrData;
        fun_next    = ALU_FUN;
        // Gate stays open for the whole ALU frame, including the ALU_EN cycle.
        gate_next   = (state == OP_A) || (state == OP_B) || (state == ALU_FUNC);

        if (tmo_fire) begin
            state_next = IDLE;
            err_next   = 1'b1;
            gate_next  = 1'b0;
        end else if (byte_vld) begin
            case (state)
                IDLE: begin
                    if (byte_data == OPC_WR) begin
                        state_next = WR_ADDR;
                    end else if (byte_data == OPC_RD) begin
                        state_next = RD_ADDR;
                    end else if (byte_data == OPC_ALU_OP) begin
                        state_next = OP_A;
                        gate_next  = 1'b1;
                    end else if (byte_data == OPC_ALU_NOP) begin
                        state_next = ALU_FUNC;
                        gate_next  = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                WR_ADDR: begin
                    addr_next  = byte_data[ADDR_WIDTH-1:0];
                    state_next = WR_DATA;
                end
                WR_DATA: begin
                    wdata_next = byte_data;
                    wr_en_next = 1'b1;
                    state_next = IDLE;
                end
                RD_ADDR: begin
                    addr_next  = byte_data[ADDR_WIDTH-1:0];
                    rd_en_next = 1'b1;
                    state_next = IDLE;
                end
                OP_A: begin
                    addr_next  = '0;
                    wdata_next = byte_data;
                    wr_en_next = 1'b1;
                    state_next = OP_B;
                end
                OP_B: begin
                    addr_next  = ADDR_WIDTH'(1);
                    wdata_next = byte_data;
                    wr_en_next = 1'b1;
                    state_next = ALU_FUNC;
                end
                ALU_FUNC: begin
                    fun_next    = byte_data[3:0];
                    alu_en_next = 1'b1;
                    state_next  = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Self-checking bench for uart_rx_cmd_decoder: directed frames plus random frames,
// with a negedge monitor popping expected strobe events from a queue.
module tb_uart_rx_cmd_decoder;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int TMO = 16;

    localparam logic [2:0] K_WR  = 3'd1;
    localparam logic [2:0] K_RD  = 3'd2;
    localparam logic [2:0] K_ALU = 3'd3;
    localparam logic [2:0] K_ERR = 3'd4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] RX_P_DATA = '0;
    logic          RX_D_VLD = 1'b0;
    logic          RF_WrEn;
    logic          RF_RdEn;
    logic [AW-1:0] RF_Address;
    logic [DW-1:0] RF_WrData;
    logic          ALU_EN;
    logic [3:0]    ALU_FUN;
    logic          CLK_GATE_EN;
    logic          cmd_err;
    logic          busy;
    logic [2:0]    fsm_state;

    // Event word: {kind[2:0], addr[3:0], data[7:0]}
    logic [14:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [7:0]  tx_buf[0:7];
    int          tx_len;

    int          mon_n;
    logic [14:0] mon_ev;
    logic [14:0] mon_exp;

    uart_rx_cmd_decoder #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .RF_WrEn     (RF_WrEn),
        .RF_RdEn     (RF_RdEn),
        .RF_Address  (RF_Address),
        .RF_WrData   (RF_WrData),
        .ALU_EN      (ALU_EN),
        .ALU_FUN     (ALU_FUN),
        .CLK_GATE_EN (CLK_GATE_EN),
        .cmd_err     (cmd_err),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- expected-event builders ----------------
    function automatic logic [14:0] ev_wr(input logic [3:0] a, input logic [7:0] d);
        return {K_WR, a, d};
    endfunction

    function automatic logic [14:0] ev_rd(input logic [3:0] a);
        return {K_RD, a, 8'h00};
    endfunction

    function automatic logic [14:0] ev_alu(input logic [3:0] f);
        return {K_ALU, 4'h0, 4'h0, f};
    endfunction

    function automatic logic [14:0] ev_err();
        return {K_ERR, 12'h000};
    endfunction

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic drive_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle(input int n);
        RX_D_VLD = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_buf();
        for (int i = 0; i < tx_len; i++) drive_byte(tx_buf[i]);
        RX_D_VLD = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (RST === 1'b1 && (RF_WrEn || RF_RdEn || ALU_EN || cmd_err)) begin
            mon_n = int'(RF_WrEn) + int'(RF_RdEn) + int'(ALU_EN) + int'(cmd_err);
            n_checks++;
            if (mon_n != 1) $display("FAIL strobe_excl: %0d strobes high at once, required 1", mon_n);
            else n_pass++;

            if (RF_WrEn)      mon_ev = {K_WR, RF_Address, RF_WrData};
            else if (RF_RdEn) mon_ev = {K_RD, RF_Address, 8'h00};
            else if (ALU_EN)  mon_ev = {K_ALU, 4'h0, 4'h0, ALU_FUN};
            else              mon_ev = {K_ERR, 12'h000};

            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: got %h, required none (t=%0t)", mon_ev, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_ev !== mon_exp) $display("FAIL event: got %h, required %h (t=%0t)", mon_ev, mon_exp, $time);
                else n_pass++;
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b0;
        RX_D_VLD = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, cmd_err, busy} !== 22'h0)
            $display("FAIL reset_outputs: got %h, required 0",
                     {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, cmd_err, busy});
        else n_pass++;
        n_checks++;
        if (fsm_state !== 3'd0) $display("FAIL reset_state: got %0d, required 0", fsm_state);
        else n_pass++;
        RST = 1'b1;
        drive_idle(1);
    endtask

    task automatic test_write();
        exp_q.push_back(ev_wr(4'h5, 8'h3C));
        drive_byte(8'hAA);
        drive_byte(8'h05);
        drive_byte(8'h3C);
        RX_D_VLD = 1'b0;
        n_checks++;
        if ({RF_WrEn, RF_Address, RF_WrData} !== {1'b1, 4'h5, 8'h3C})
            $display("FAIL write_strobe: got %b/%h/%h, required 1/5/3c", RF_WrEn, RF_Address, RF_WrData);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL write_busy_after: got %b, required 0", busy);
        else n_pass++;
        drive_idle(1);
        n_checks++;
        if (RF_WrEn !== 1'b0) $display("FAIL write_one_cycle: got %b, required 0", RF_WrEn);
        else n_pass++;

        // Spaced bytes: FSM must hold state and latched address between them.
        exp_q.push_back(ev_wr(4'hE, 8'h81));
        drive_byte(8'hAA);
        drive_idle(3);
        drive_byte(8'h0E);
        drive_idle(2);
        n_checks++;
        if ({busy, RF_Address, RF_WrEn} !== {1'b1, 4'hE, 1'b0})
            $display("FAIL write_hold: got busy=%b addr=%h wren=%b, required 1/e/0", busy, RF_Address, RF_WrEn);
        else n_pass++;
        drive_byte(8'h81);
        drive_idle(2);
    endtask

    task automatic test_read();
        exp_q.push_back(ev_rd(4'hA));
        drive_byte(8'hBB);
        drive_byte(8'h1A);
        RX_D_VLD = 1'b0;
        n_checks++;
        if ({RF_RdEn, RF_WrEn, RF_Address} !== {1'b1, 1'b0, 4'hA})
            $display("FAIL read_strobe: got rd=%b wr=%b addr=%h, required 1/0/a", RF_RdEn, RF_WrEn, RF_Address);
        else n_pass++;
        drive_idle(2);
    endtask

    task automatic test_alu_ops();
        exp_q.push_back(ev_wr(4'h0, 8'h12));
        exp_q.push_back(ev_wr(4'h1, 8'h34));
        exp_q.push_back(ev_alu(4'h2));
        n_checks++;
        if (CLK_GATE_EN !== 1'b0) $display("FAIL gate_idle: got %b, required 0", CLK_GATE_EN);
        else n_pass++;
        drive_byte(8'hCC);
        n_checks++;
        if (CLK_GATE_EN !== 1'b1) $display("FAIL gate_rise: got %b, required 1", CLK_GATE_EN);
        else n_pass++;
        drive_byte(8'h12);
        n_checks++;
        if ({RF_WrEn, RF_Address, RF_WrData, CLK_GATE_EN} !== {1'b1, 4'h0, 8'h12, 1'b1})
            $display("FAIL alu_opa: got %b/%h/%h/%b, required 1/0/12/1", RF_WrEn, RF_Address, RF_WrData, CLK_GATE_EN);
        else n_pass++;
        drive_byte(8'h34);
        n_checks++;
        if ({RF_WrEn, RF_Address, RF_WrData} !== {1'b1, 4'h1, 8'h34})
            $display("FAIL alu_opb: got %b/%h/%h, required 1/1/34", RF_WrEn, RF_Address, RF_WrData);
        else n_pass++;
        drive_byte(8'h02);
        RX_D_VLD = 1'b0;
        n_checks++;
        if ({ALU_EN, ALU_FUN, CLK_GATE_EN, RF_WrEn} !== {1'b1, 4'h2, 1'b1, 1'b0})
            $display("FAIL alu_en: got en=%b fun=%h gate=%b wr=%b, required 1/2/1/0", ALU_EN, ALU_FUN, CLK_GATE_EN, RF_WrEn);
        else n_pass++;
        drive_idle(1);
        n_checks++;
        if ({CLK_GATE_EN, ALU_EN, busy, ALU_FUN} !== {1'b0, 1'b0, 1'b0, 4'h2})
            $display("FAIL gate_fall: got gate=%b en=%b busy=%b fun=%h, required 0/0/0/2", CLK_GATE_EN, ALU_EN, busy, ALU_FUN);
        else n_pass++;
        drive_idle(1);
    endtask

    task automatic test_error_then_alu();
        exp_q.push_back(ev_err());
        drive_byte(8'h55);
        RX_D_VLD = 1'b0;
        n_checks++;
        if ({cmd_err, busy} !== 2'b10) $display("FAIL err_pulse: got err=%b busy=%b, required 1/0", cmd_err, busy);
        else n_pass++;
        drive_idle(1);
        n_checks++;
        if (cmd_err !== 1'b0) $display("FAIL err_one_cycle: got %b, required 0", cmd_err);
        else n_pass++;

        exp_q.push_back(ev_alu(4'h7));
        drive_byte(8'hDD);
        n_checks++;
        if (CLK_GATE_EN !== 1'b1) $display("FAIL gate_dd: got %b, required 1", CLK_GATE_EN);
        else n_pass++;
        drive_byte(8'h07);
        RX_D_VLD = 1'b0;
        n_checks++;
        if ({ALU_EN, ALU_FUN} !== {1'b1, 4'h7}) $display("FAIL alu_nop: got en=%b fun=%h, required 1/7", ALU_EN, ALU_FUN);
        else n_pass++;
        drive_idle(2);
    endtask

    task automatic test_payload_opcodes();
        exp_q.push_back(ev_wr(4'hA, 8'hBB));
        drive_byte(8'hAA);
        drive_byte(8'hAA);
        drive_byte(8'hBB);
        exp_q.push_back(ev_wr(4'h7, 8'hAA));
        drive_byte(8'hAA);
        drive_byte(8'hF7);
        drive_byte(8'hAA);
        RX_D_VLD = 1'b0;
        n_checks++;
        if ({RF_WrEn, RF_Address, RF_WrData, ALU_FUN} !== {1'b1, 4'h7, 8'hAA, 4'h7})
            $display("FAIL payload_wr: got %b/%h/%h fun=%h, required 1/7/aa fun=7", RF_WrEn, RF_Address, RF_WrData, ALU_FUN);
        else n_pass++;
        drive_idle(2);
    endtask

    task automatic test_back_to_back_random();
        for (int f = 0; f < 16; f++) begin
            int         kind;
            logic [7:0] a;
            logic [7:0] b;
            logic [7:0] c;
            kind = $urandom_range(0, 4);
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = 8'($urandom_range(0, 255));
            case (kind)
                0: begin
                    tx_buf[0] = 8'hAA; tx_buf[1] = a; tx_buf[2] = b; tx_len = 3;
                    exp_q.push_back(ev_wr(a[3:0], b));
                end
                1: begin
                    tx_buf[0] = 8'hBB; tx_buf[1] = a; tx_len = 2;
                    exp_q.push_back(ev_rd(a[3:0]));
                end
                2: begin
                    tx_buf[0] = 8'hCC; tx_buf[1] = a; tx_buf[2] = b; tx_buf[3] = c; tx_len = 4;
                    exp_q.push_back(ev_wr(4'h0, a));
                    exp_q.push_back(ev_wr(4'h1, b));
                    exp_q.push_back(ev_alu(c[3:0]));
                end
                3: begin
                    tx_buf[0] = 8'hDD; tx_buf[1] = a; tx_len = 2;
                    exp_q.push_back(ev_alu(a[3:0]));
                end
                default: begin
                    while (a == 8'hAA || a == 8'hBB || a == 8'hCC || a == 8'hDD)
                        a = 8'($urandom_range(0, 255));
                    tx_buf[0] = a; tx_len = 1;
                    exp_q.push_back(ev_err());
                end
            endcase
            send_buf();
            drive_idle($urandom_range(0, 2));
        end
        drive_idle(3);
    endtask

    task automatic test_reset_mid_frame();
        drive_byte(8'hAA);
        drive_byte(8'h03);
        RX_D_VLD = 1'b0;
        n_checks++;
        if ({busy, RF_Address} !== {1'b1, 4'h3}) $display("FAIL mid_pre: got busy=%b addr=%h, required 1/3", busy, RF_Address);
        else n_pass++;
        RST = 1'b0;
        #1;
        n_checks++;
        if ({busy, RF_Address, RF_WrData, CLK_GATE_EN} !== 14'h0)
            $display("FAIL mid_reset: got busy=%b addr=%h data=%h gate=%b, required all 0", busy, RF_Address, RF_WrData, CLK_GATE_EN);
        else n_pass++;
        drive_idle(2);
        RST = 1'b1;
        drive_idle(1);
        exp_q.push_back(ev_err());
        drive_byte(8'h44);
        RX_D_VLD = 1'b0;
        n_checks++;
        if ({cmd_err, RF_WrEn} !== 2'b10) $display("FAIL mid_after: got err=%b wr=%b, required 1/0", cmd_err, RF_WrEn);
        else n_pass++;
        drive_idle(2);
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout();
        exp_q.push_back(ev_err());
        drive_byte(8'hAA);
        drive_idle(TMO - 1);
        n_checks++;
        if ({busy, cmd_err} !== 2'b10) $display("FAIL tmo_before: got busy=%b err=%b, required 1/0", busy, cmd_err);
        else n_pass++;
        drive_idle(1);
        n_checks++;
        if ({busy, cmd_err, RF_WrEn} !== 3'b010) $display("FAIL tmo_fire: got busy=%b err=%b wr=%b, required 0/1/0", busy, cmd_err, RF_WrEn);
        else n_pass++;
        drive_idle(2);
        exp_q.push_back(ev_rd(4'h2));
        drive_byte(8'hBB);
        drive_byte(8'h02);
        RX_D_VLD = 1'b0;
        n_checks++;
        if ({RF_RdEn, RF_Address} !== {1'b1, 4'h2}) $display("FAIL tmo_read: got rd=%b addr=%h, required 1/2", RF_RdEn, RF_Address);
        else n_pass++;
        drive_idle(2);
    endtask
`else
    task automatic test_no_timeout_wait();
        exp_q.push_back(ev_wr(4'h5, 8'h3C));
        drive_byte(8'hAA);
        drive_idle(40);
        n_checks++;
        if ({busy, cmd_err} !== 2'b10) $display("FAIL wait_hold: got busy=%b err=%b, required 1/0", busy, cmd_err);
        else n_pass++;
        drive_byte(8'h05);
        drive_byte(8'h3C);
        RX_D_VLD = 1'b0;
        n_checks++;
        if ({RF_WrEn, RF_Address, RF_WrData} !== {1'b1, 4'h5, 8'h3C})
            $display("FAIL wait_write: got %b/%h/%h, required 1/5/3c", RF_WrEn, RF_Address, RF_WrData);
        else n_pass++;
        drive_idle(2);
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu_ops();
        test_error_then_alu();
        test_payload_opcodes();
        test_back_to_back_random();
        test_reset_mid_frame();
`ifdef CMD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout_wait();
`endif
        drive_idle(4);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d expected events never seen, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
